mem_access_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, between the EX/MEM ALU buffer and the MEM/WB result buffer. It takes the registered ALU result as an effective address, issues a single load or store on a request/ready data-memory port, and aligns and extends load data. It stalls the upstream stages while an access is outstanding and presents one registered result per instruction to writeback.

---
 rtl/mem_access_stage.sv | 215 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one load/store per instruction on a req/ready port and aligns load data.
// Optional wait-state abort path is compiled in with MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall,
  output logic [31:0] mem_result,
  output logic        out_valid,
  output logic        misaligned,
  output logic        timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_wmask_q, dmem_wmask_d;
  logic [31:0] mem_result_q, mem_result_d;
  logic        out_valid_q, out_valid_d;
  logic        misaligned_q, misaligned_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_load_q, is_load_d;

  logic        is_mem, ld_bad, st_bad, half_bad, word_bad, fault, access;
  logic        abort;
  logic [31:0] rd_shift, load_data;
  logic [3:0]  st_mask;
  logic [31:0] st_data;

  // Decode: anything that cannot be issued as a single aligned access is a fault.
  always_comb begin
    is_mem   = mem_read | mem_write;
    ld_bad   = (funct3 == 3'd3) | (funct3 == 3'd6) | (funct3 == 3'd7);
    st_bad   = funct3 > 3'd2;
    half_bad = (funct3[1:0] == 2'b01) & alu_result[0];
    word_bad = (funct3[1:0] == 2'b10) & (alu_result[1:0] != 2'b00);
    fault    = is_mem & ((mem_read & mem_write) | (mem_read & ld_bad) |
                         (mem_write & st_bad) | half_bad | word_bad);
    access   = is_mem & ~fault;
  end

  always_comb begin
    st_mask = 4'b1111;
    st_data = store_data;
    case (funct3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << alu_result[1:0];
        st_data = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_mask = alu_result[1] ? 4'b1100 : 4'b0011;
        st_data = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment uses the byte offset captured at issue time.
  always_comb begin
    rd_shift  = dmem_rdata >> {addr_lo_q, 3'b000};
    load_data = rd_shift;
    case (funct3_q)
      3'd0:    load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd4:    load_data = {24'd0, rd_shift[7:0]};
      3'd5:    load_data = {16'd0, rd_shift[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Abort on the edge that would complete the WAIT_LIMIT-th empty wait cycle.
  assign abort = (state_q == WAIT) & ~dmem_ready & (cnt_q == CW'(WAIT_LIMIT - 1));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = abort;
    if (state_q == IDLE) cnt_d = '0;
    else if (~dmem_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_wait_limit;
  assign unused_wait_limit = ^WAIT_LIMIT;
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wmask_d = dmem_wmask_q;
    mem_result_d = mem_result_q;
    out_valid_d  = 1'b0;
    misaligned_d = 1'b0;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    is_load_d    = is_load_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (access) begin
            state_d      = WAIT;
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write;
            dmem_addr_d  = {alu_result[31:2], 2'b00};
            dmem_wdata_d = st_data;
            dmem_wmask_d = mem_write ? st_mask : 4'b0000;
            addr_lo_d    = alu_result[1:0];
            funct3_d     = funct3;
            is_load_d    = mem_read;
          end else begin
            out_valid_d  = 1'b1;
            misaligned_d = fault;
            mem_result_d = alu_result;
          end
        end
      end
      default: begin
        if (dmem_ready) begin
          state_d      = IDLE;
          dmem_req_d   = 1'b0;
          out_valid_d  = 1'b1;
          mem_result_d = is_load_q ? load_data : alu_result;
        end else if (abort) begin
          state_d      = IDLE;
          dmem_req_d   = 1'b0;
          out_valid_d  = 1'b1;
          mem_result_d = 32'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      dmem_wmask_q <= 4'd0;
      mem_result_q <= 32'd0;
      out_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
      addr_lo_q    <= 2'd0;
      funct3_q     <= 3'd0;
      is_load_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wmask_q <= dmem_wmask_d;
      mem_result_q <= mem_result_d;
      out_valid_q  <= out_valid_d;
      misaligned_q <= misaligned_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      is_load_q    <= is_load_d;
    end
  end

  assign stall = rst & (((state_q == IDLE) & in_valid & access) |
                        ((state_q == WAIT) & ~dmem_ready & ~abort));

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_wmask = dmem_wmask_q;
  assign mem_result = mem_result_q;
  assign out_valid  = out_valid_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; abort checks depend on MEM_ACCESS_TIMEOUT_EN.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, mem_read, mem_write, dmem_ready;
  logic [31:0] alu_result, store_data, dmem_rdata;
  logic [2:0]  funct3;
  logic        dmem_req, dmem_we, stall, out_valid, misaligned, timeout;
  logic [31:0] dmem_addr, dmem_wdata, mem_result;
  logic [3:0]  dmem_wmask;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
    .store_data(store_data), .funct3(funct3), .mem_read(mem_read), .mem_write(mem_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall(stall), .mem_result(mem_result), .out_valid(out_valid),
    .misaligned(misaligned), .timeout(timeout)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0;
    alu_result = 0; store_data = 0; dmem_ready = 0; dmem_rdata = 0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd);
    in_valid = 1; mem_read = rd; mem_write = wr; funct3 = f3;
    alu_result = addr; store_data = sd;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 0;
    step(); step();
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", dmem_req); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (mem_result !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", mem_result); end
    n_cmp++; if ({dmem_we, dmem_wmask, misaligned, timeout} !== 7'd0) begin n_bad++; $display("FAIL reset_flags got %b want 0", {dmem_we, dmem_wmask, misaligned, timeout}); end
    n_cmp++; if (dmem_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr got %h want 0", dmem_addr); end
    rst = 1; step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_no_valid got %b want 0", out_valid); end
  endtask

  task automatic test_load_sext();
    issue(1, 0, 3'd0, 32'h0000_1003, 0); #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lb_stall_accept got %b want 1", stall); end
    step();
    n_cmp++; if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL lb_req got %b want 1", dmem_req); end
    n_cmp++; if (dmem_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL lb_addr got %h want 00001000", dmem_addr); end
    n_cmp++; if (dmem_we !== 1'b0) begin n_bad++; $display("FAIL lb_we got %b want 0", dmem_we); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lb_stall_w1 got %b want 1", stall); end
    step();
    n_cmp++; if (stall !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL lb_stall_w2 got %b/%b want 1/0", stall, out_valid); end
    step();
    dmem_ready = 1; dmem_rdata = 32'h8011_2233; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lb_stall_ready got %b want 0", stall); end
    step();
    idle_inputs();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lb_valid got %b want 1", out_valid); end
    n_cmp++; if (mem_result !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_result got %h want ffffff80", mem_result); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL lb_req_drop got %b want 0", dmem_req); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lb_single_pulse got %b want 0", out_valid); end
  endtask

  task automatic test_load_lanes();
    issue(1, 0, 3'd4, 32'h0000_1001, 0);
    step(); dmem_ready = 1; dmem_rdata = 32'h8011_2233;
    step(); idle_inputs();
    n_cmp++; if (mem_result !== 32'h0000_0022) begin n_bad++; $display("FAIL lbu_result got %h want 00000022", mem_result); end
    issue(1, 0, 3'd1, 32'h0000_1002, 0);
    step(); dmem_ready = 1; dmem_rdata = 32'h8011_2233;
    step(); idle_inputs();
    n_cmp++; if (mem_result !== 32'hFFFF_8011) begin n_bad++; $display("FAIL lh_result got %h want ffff8011", mem_result); end
    issue(1, 0, 3'd5, 32'h0000_1000, 0);
    step(); dmem_ready = 1; dmem_rdata = 32'h8011_F233;
    step(); idle_inputs();
    n_cmp++; if (mem_result !== 32'h0000_F233) begin n_bad++; $display("FAIL lhu_result got %h want 0000f233", mem_result); end
    step();
  endtask

  task automatic test_store();
    issue(0, 1, 3'd1, 32'h0000_2002, 32'h0000_ABCD);
    step();
    n_cmp++; if (dmem_wmask !== 4'b1100) begin n_bad++; $display("FAIL sh_mask got %b want 1100", dmem_wmask); end
    n_cmp++; if (dmem_wdata !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL sh_wdata got %h want abcdabcd", dmem_wdata); end
    n_cmp++; if (dmem_addr !== 32'h0000_2000) begin n_bad++; $display("FAIL sh_addr got %h want 00002000", dmem_addr); end
    n_cmp++; if (dmem_we !== 1'b1 || dmem_req !== 1'b1) begin n_bad++; $display("FAIL sh_we_req got %b/%b want 1/1", dmem_we, dmem_req); end
    dmem_ready = 1;
    step(); idle_inputs();
    n_cmp++; if (out_valid !== 1'b1 || mem_result !== 32'h0000_2002) begin n_bad++; $display("FAIL sh_done got %b/%h want 1/00002002", out_valid, mem_result); end
    issue(0, 1, 3'd0, 32'h0000_5001, 32'h1234_565A);
    step();
    n_cmp++; if (dmem_wmask !== 4'b0010 || dmem_wdata !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL sb_lanes got %b/%h want 0010/5a5a5a5a", dmem_wmask, dmem_wdata); end
    dmem_ready = 1;
    step(); idle_inputs();
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL sb_req_drop got %b want 0", dmem_req); end
    step();
  endtask

  task automatic test_misaligned();
    issue(1, 0, 3'd2, 32'h0000_3001, 0); #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mis_stall got %b want 0", stall); end
    step(); idle_inputs();
    n_cmp++; if (misaligned !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL mis_flags got %b/%b want 1/1", misaligned, out_valid); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL mis_noreq got %b want 0", dmem_req); end
    n_cmp++; if (mem_result !== 32'h0000_3001) begin n_bad++; $display("FAIL mis_result got %h want 00003001", mem_result); end
    step();
    n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL mis_pulse got %b want 0", misaligned); end
    issue(0, 1, 3'd3, 32'h0000_3000, 0);
    step(); idle_inputs();
    n_cmp++; if (misaligned !== 1'b1 || dmem_req !== 1'b0) begin n_bad++; $display("FAIL bad_f3_store got %b/%b want 1/0", misaligned, dmem_req); end
    issue(1, 1, 3'd2, 32'h0000_3000, 0);
    step(); idle_inputs();
    n_cmp++; if (misaligned !== 1'b1 || dmem_req !== 1'b0) begin n_bad++; $display("FAIL rd_wr_both got %b/%b want 1/0", misaligned, dmem_req); end
    step();
  endtask

  task automatic test_back_to_back();
    issue(0, 0, 3'd0, 32'h11, 0); #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall0 got %b want 0", stall); end
    step();
    alu_result = 32'h22; #1;
    n_cmp++; if (out_valid !== 1'b1 || mem_result !== 32'h11) begin n_bad++; $display("FAIL b2b_first got %b/%h want 1/11", out_valid, mem_result); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall1 got %b want 0", stall); end
    step(); idle_inputs();
    n_cmp++; if (out_valid !== 1'b1 || mem_result !== 32'h22) begin n_bad++; $display("FAIL b2b_second got %b/%h want 1/22", out_valid, mem_result); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_access();
    issue(1, 0, 3'd2, 32'h0000_6000, 0);
    step();
    n_cmp++; if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_req got %b want 1", dmem_req); end
    rst = 0; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall got %b want 0", stall); end
    step(); idle_inputs();
    n_cmp++; if (dmem_req !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_drop got %b/%b want 0/0", dmem_req, out_valid); end
    n_cmp++; if ({dmem_addr, dmem_we, mem_result} !== 65'd0) begin n_bad++; $display("FAIL rst_mid_clear got %h/%b/%h want 0", dmem_addr, dmem_we, mem_result); end
    rst = 1; dmem_ready = 1;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mid_discard got %b/%b want 0/0", out_valid, dmem_req); end
    dmem_ready = 0;
  endtask

  task automatic test_timeout();
`ifdef MEM_ACCESS_TIMEOUT_EN
    issue(1, 0, 3'd2, 32'h0000_4000, 0);
    step(); step(); step(); step(); #1;
    n_cmp++; if (stall !== 1'b0 || dmem_req !== 1'b1) begin n_bad++; $display("FAIL to_limit_cycle got %b/%b want 0/1", stall, dmem_req); end
    step(); idle_inputs();
    n_cmp++; if (timeout !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL to_flags got %b/%b want 1/1", timeout, out_valid); end
    n_cmp++; if (mem_result !== 32'd0 || dmem_req !== 1'b0) begin n_bad++; $display("FAIL to_result got %h/%b want 0/0", mem_result, dmem_req); end
    step();
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_pulse got %b want 0", timeout); end
    issue(1, 0, 3'd2, 32'h0000_4000, 0);
    step(); step(); step(); step();
    dmem_ready = 1; dmem_rdata = 32'h1234_5678;
    step(); idle_inputs();
    n_cmp++; if (timeout !== 1'b0 || out_valid !== 1'b1 || mem_result !== 32'h1234_5678) begin n_bad++; $display("FAIL to_ready_wins got %b/%b/%h want 0/1/12345678", timeout, out_valid, mem_result); end
    step();
`else
    issue(1, 0, 3'd2, 32'h0000_4000, 0);
    for (int i = 0; i < 10; i++) step();
    n_cmp++; if (dmem_req !== 1'b1 || stall !== 1'b1 || timeout !== 1'b0) begin n_bad++; $display("FAIL noto_hold got %b/%b/%b want 1/1/0", dmem_req, stall, timeout); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL noto_novalid got %b want 0", out_valid); end
    dmem_ready = 1; dmem_rdata = 32'h1234_5678;
    step(); idle_inputs();
    n_cmp++; if (out_valid !== 1'b1 || mem_result !== 32'h1234_5678 || timeout !== 1'b0) begin n_bad++; $display("FAIL noto_done got %b/%h/%b want 1/12345678/0", out_valid, mem_result, timeout); end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_load_sext();
    test_load_lanes();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
